// File: rtl/pixel_mux_sequencer.sv
// Pixel lane-mux sequencer: streams source words, selects immediate lanes, writes results.
// Optional LANE_ROTATE_EN: rotates the lane mask left by one after every accepted write.
module pixel_mux_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  src_base,
  input  logic [ADDR_W-1:0]  dst_base,
  input  logic [COUNT_W-1:0] word_count,
  input  logic [31:0]        immediate_in,
  input  logic [3:0]         lane_mask,
  input  logic [31:0]        mem_rd_data,
  input  logic               mem_wait,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  output logic               mem_wr_en,
  output logic [ADDR_W-1:0]  mem_wr_addr,
  output logic [31:0]        pixel_word,
  output logic [31:0]        immediate_out,
  output logic [3:0]         select_pixel,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  src_q, src_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] idx_q, idx_d;
  logic [3:0]         mask_q, mask_d;
  logic [31:0]        imm_q, imm_d;
  logic [31:0]        pix_q, pix_d;

  // one extra bit so idx+1 never aliases back below word_count
  logic [COUNT_W:0]   idx_inc;
  logic [ADDR_W-1:0]  idx_addr;

  assign idx_inc  = {1'b0, idx_q} + (COUNT_W+1)'(1);
  assign idx_addr = ADDR_W'(idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
      imm_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      imm_q   <= imm_d;
      pix_q   <= pix_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    mask_d       = mask_q;
    imm_d        = imm_q;
    pix_d        = pix_q;
    mem_rd_en    = 1'b0;
    mem_rd_addr  = '0;
    mem_wr_en    = 1'b0;
    mem_wr_addr  = '0;
    select_pixel = 4'b0000;
    done         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          cnt_d   = word_count;
          imm_d   = immediate_in;
          mask_d  = lane_mask;
          idx_d   = '0;
          state_d = (word_count != '0) ? S_READ : S_FIN;
        end
      end
      S_READ: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = src_q + idx_addr;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        pix_d   = mem_rd_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_wr_en    = 1'b1;
        mem_wr_addr  = dst_q + idx_addr;
        select_pixel = mask_q;
        if (!mem_wait) begin
          idx_d = idx_inc[COUNT_W-1:0];
`ifdef LANE_ROTATE_EN
          mask_d = {mask_q[2:0], mask_q[3]};
`else
          mask_d = mask_q;
`endif
          state_d = (idx_inc < {1'b0, cnt_q}) ? S_READ : S_FIN;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign pixel_word    = pix_q;
  assign immediate_out = imm_q;

endmodule

// File: tb/tb_pixel_mux_sequencer.sv
// Bench for pixel_mux_sequencer: job-level scoreboard of reads/writes plus directed literals.
// Build with LANE_ROTATE_EN defined to exercise the rotating lane mask.
module tb_pixel_mux_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] src_base, dst_base, word_count;
  logic [31:0] immediate_in;
  logic [3:0]  lane_mask;
  logic [31:0] mem_rd_data;
  logic        mem_wait;
  logic        mem_rd_en, mem_wr_en, busy, done;
  logic [15:0] mem_rd_addr, mem_wr_addr;
  logic [31:0] pixel_word, immediate_out;
  logic [3:0]  select_pixel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_mux_sequencer #(.ADDR_W(16), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_base(src_base), .dst_base(dst_base),
    .word_count(word_count), .immediate_in(immediate_in),
    .lane_mask(lane_mask), .mem_rd_data(mem_rd_data),
    .mem_wait(mem_wait), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .pixel_word(pixel_word),
    .immediate_out(immediate_out), .select_pixel(select_pixel),
    .busy(busy), .done(done)
  );

  // source memory: one-cycle read latency
  logic [31:0] mem [0:65535];
  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 32'h0;

  typedef struct packed {
    logic [15:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } wr_t;

  logic [15:0] exp_rd[$];
  wr_t         exp_wr[$];
  logic [31:0] mux_log[$];
  logic [3:0]  sel_log[$];
  logic [15:0] rd_log[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mux(input logic [31:0] p,
                                           input logic [31:0] im,
                                           input logic [3:0] s);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = s[k] ? im[8*k +: 8] : p[8*k +: 8];
    return r;
  endfunction

  // expected job effect: word i read from src+i, merged, written to dst+i
  task automatic push_job(input logic [15:0] s, input logic [15:0] d,
                          input int n, input logic [3:0] m,
                          input logic [31:0] im);
    logic [3:0]  mm;
    logic [15:0] sa, da;
    wr_t w;
    mm = m;
    for (int i = 0; i < n; i++) begin
      sa = s + 16'(i);
      da = d + 16'(i);
      exp_rd.push_back(sa);
      w.a = da;
      w.s = mm;
      w.d = lane_mux(mem[sa], im, mm);
      exp_wr.push_back(w);
`ifdef LANE_ROTATE_EN
      mm = {mm[2:0], mm[3]};
`endif
    end
  endtask

  // cycle-by-cycle compare against the scoreboard
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (mem_rd_en) begin
        chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) begin
          chk("rd_addr", 32'(mem_rd_addr), 32'(exp_rd[0]));
          void'(exp_rd.pop_front());
        end
      end
      if (mem_wr_en) begin
        chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          chk("wr_addr", 32'(mem_wr_addr), 32'(exp_wr[0].a));
          chk("wr_sel", 32'(select_pixel), 32'(exp_wr[0].s));
          chk("wr_data", lane_mux(pixel_word, immediate_out, select_pixel),
              exp_wr[0].d);
          if (!mem_wait) void'(exp_wr.pop_front());
        end
      end else begin
        chk("sel_idle", 32'(select_pixel), 32'd0);
      end
      if (done)
        chk("done_drained", 32'(exp_rd.size() + exp_wr.size()), 32'd0);
    end
  end

  task automatic run_job(input logic [15:0] s, input logic [15:0] d,
                         input int n, input logic [3:0] m,
                         input logic [31:0] im, input int st_at,
                         input int st_len, input int inj,
                         output int first_wr, output int done_c,
                         output int bsy, output int wr_c, output int rd_c);
    int c;
    push_job(s, d, n, m, im);
    mux_log.delete();
    sel_log.delete();
    rd_log.delete();
    src_base = s; dst_base = d; word_count = 16'(n);
    lane_mask = m; immediate_in = im; start = 1'b1;
    first_wr = -1; done_c = -1; bsy = 0; wr_c = 0; rd_c = 0;
    c = 0;
    while (c < 400) begin
      mem_wait = (st_len > 0) && (c >= st_at) && (c < st_at + st_len);
      @(negedge clk);
      if (busy) bsy++;
      if (mem_rd_en) begin
        rd_c++;
        rd_log.push_back(mem_rd_addr);
      end
      if (mem_wr_en) begin
        wr_c++;
        if (first_wr < 0) first_wr = c;
        if (!mem_wait) begin
          mux_log.push_back(lane_mux(pixel_word, immediate_out, select_pixel));
          sel_log.push_back(select_pixel);
        end
      end
      if (done) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
      c++;
      start = (c == inj);
      if (c == inj) begin
        src_base = s ^ 16'h0F0F; dst_base = d ^ 16'h00F0;
        word_count = 16'(n + 3); lane_mask = ~m;
      end
    end
    if (done_c < 0) chk("done_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; mem_wait = 1'b0;
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  int fw, dc, bs, wc, rc;

  initial begin
    for (int i = 0; i < 65536; i++)
      mem[i] = {16'(i) ^ 16'h5A5A, 16'(i)};
    mem[16'h0010] = 32'h44332211;
    mem[16'h0011] = 32'h88776655;
    rst = 1'b1; start = 1'b0; mem_wait = 1'b0;
    src_base = '0; dst_base = '0; word_count = '0;
    immediate_in = '0; lane_mask = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", 32'(|{mem_rd_en, mem_wr_en, busy, done, select_pixel,
        mem_rd_addr, mem_wr_addr, pixel_word, immediate_out}), 32'd0);
    @(posedge clk); #1;

    // reset while a write is stalled
    push_job(16'h0030, 16'h0050, 2, 4'b0011, 32'h12345678);
    src_base = 16'h0030; dst_base = 16'h0050; word_count = 16'd2;
    lane_mask = 4'b0011; immediate_in = 32'h12345678; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 mem_wait = 1'b1;
    @(negedge clk);
    chk("rst_pre_wr", 32'(mem_wr_en), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_wr_held", 32'(mem_wr_en), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; mem_wait = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    @(negedge clk);
    chk("rst_abort_outs", 32'(|{mem_rd_en, mem_wr_en, busy, done, select_pixel,
        mem_rd_addr, mem_wr_addr, pixel_word, immediate_out}), 32'd0);
    dc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("rst_no_done", 32'(dc), 32'd0);
    @(posedge clk); #1;

    // nominal two-word job
    run_job(16'h0010, 16'h0080, 2, 4'b0101, 32'hAAAAAAAA, -1, 0, -1,
            fw, dc, bs, wc, rc);
    chk("t2_first_wr", 32'(fw), 32'd3);
    chk("t2_done_cyc", 32'(dc), 32'd7);
    chk("t2_busy_cyc", 32'(bs), 32'd7);
    chk("t2_wr_cyc", 32'(wc), 32'd2);
    chk("t2_rd_cnt", 32'(rc), 32'd2);
    chk("t2_mux0", mux_log[0], 32'h44AA22AA);
    chk("t2_sel0", 32'(sel_log[0]), 32'h5);
`ifdef LANE_ROTATE_EN
    chk("t2_mux1", mux_log[1], 32'hAA77AA55);
    chk("t2_sel1", 32'(sel_log[1]), 32'hA);
`else
    chk("t2_mux1", mux_log[1], 32'h88AA66AA);
    chk("t2_sel1", 32'(sel_log[1]), 32'h5);
`endif

    // zero-length job
    run_job(16'h0100, 16'h0200, 0, 4'b1111, 32'h0, -1, 0, -1,
            fw, dc, bs, wc, rc);
    chk("t3_done_cyc", 32'(dc), 32'd1);
    chk("t3_busy_cyc", 32'(bs), 32'd1);
    chk("t3_rd_cnt", 32'(rc), 32'd0);
    chk("t3_wr_cyc", 32'(wc), 32'd0);

    // three-cycle stall on the first write
    run_job(16'h0020, 16'h0040, 3, 4'b1000, 32'hDEADBEEF, 3, 3, -1,
            fw, dc, bs, wc, rc);
    chk("t4_first_wr", 32'(fw), 32'd3);
    chk("t4_wr_cyc", 32'(wc), 32'd6);
    chk("t4_done_cyc", 32'(dc), 32'd13);
    chk("t4_rd1_addr", 32'(rd_log[1]), 32'h0021);

    // start pulse mid-job must be ignored
    run_job(16'h0300, 16'h0400, 2, 4'b0110, 32'hCAFEF00D, -1, 0, 2,
            fw, dc, bs, wc, rc);
    chk("t5_done_cyc", 32'(dc), 32'd7);
    chk("t5_rd_cnt", 32'(rc), 32'd2);
    chk("t5_wr_cyc", 32'(wc), 32'd2);

    // source/destination address wrap
    run_job(16'hFFFF, 16'hFFFE, 2, 4'b0010, 32'h11223344, -1, 0, -1,
            fw, dc, bs, wc, rc);
    chk("t6_rd0_addr", 32'(rd_log[0]), 32'h0000FFFF);
    chk("t6_rd1_wrap", 32'(rd_log[1]), 32'h00000000);

`ifdef LANE_ROTATE_EN
    run_job(16'h0500, 16'h0600, 4, 4'b0001, 32'h99999999, -1, 0, -1,
            fw, dc, bs, wc, rc);
    chk("rot_sel0", 32'(sel_log[0]), 32'h1);
    chk("rot_sel1", 32'(sel_log[1]), 32'h2);
    chk("rot_sel2", 32'(sel_log[2]), 32'h4);
    chk("rot_sel3", 32'(sel_log[3]), 32'h8);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
